// File: rtl/fft1024_loader_pkg.sv
// Shared sizes and FSM encoding for the FFT input loader.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fft_pkg;

  localparam int FFT_N     = 1024;
  localparam int FFT_LOG2N = 10;
  localparam int Q_W       = 16;
  localparam int SAMPLE_W  = 2 * Q_W;
  localparam int ADDR_W    = 11;
  localparam int BANK_BIT  = FFT_LOG2N - 1;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_FLUSH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fft1024_loader_bit_reverse.sv
// Reverses the bit order of a W-bit index (sample position to FFT slot).
// Latency: combinational.
// Backpressure: none.
module bit_reverse #(
  parameter int W = 10
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] out_bits
);

  // Mirror each bit position across the word.
  always_comb begin
    out_bits = '0;
    for (int i = 0; i < W; i++) begin
      out_bits[i] = in_bits[W-1-i];
    end
  end

endmodule

// File: rtl/fft1024_loader.sv
// Loads one frame of complex samples into the two FFT banks in bit-reversed order, then runs the FFT core.
// Latency: write lands 1 clk after accept; fft_start 2 clks after the last accept.
// Backpressure: in_ready is high only while loading; it is low from frame close until the FFT has finished.
module fft1024_loader
  import fft_pkg::*;
#(
  parameter int N        = FFT_N,
  parameter int LOG2N    = FFT_LOG2N,
  parameter int IN_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_last,
  output logic                ce0,
  output logic                oce0,
  output logic                wre0,
  output logic [ADDR_W-1:0]   ad0,
  output logic [SAMPLE_W-1:0] din0,
  output logic                ce1,
  output logic                oce1,
  output logic                wre1,
  output logic [ADDR_W-1:0]   ad1,
  output logic [SAMPLE_W-1:0] din1,
  output logic                mem_owner,
  output logic                fft_start,
  input  logic                fft_finish,
  output logic                frame_done,
  output logic                frame_err
);

  // Top bit of the reversed index picks the bank; the rest is the address.
  localparam int               BANK     = LOG2N - 1;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t                state;
  logic [LOG2N-1:0]      count;
  logic [LOG2N-1:0]      rev;
  logic                  finish_q;
  logic                  accept;
  logic signed [Q_W-1:0] re_s;
  logic signed [Q_W-1:0] im_s;
  logic [SAMPLE_W-1:0]   wr_dat;
  logic [ADDR_W-1:0]     wr_ad;

  bit_reverse #(.W(LOG2N)) u_bitrev (
    .in_bits  (count),
    .out_bits (rev)
  );

  assign accept = in_valid & in_ready;
  assign re_s   = $signed(in_data[SAMPLE_W-1:Q_W]) >>> IN_SHIFT;
  assign im_s   = $signed(in_data[Q_W-1:0]) >>> IN_SHIFT;
  assign wr_dat = {re_s, im_s};
  assign wr_ad  = ADDR_W'(rev[BANK-1:0]);

  // Load / flush / start / wait / done sequencer; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      count      <= '0;
      finish_q   <= 1'b0;
      in_ready   <= 1'b0;
      ce0        <= 1'b0;
      oce0       <= 1'b0;
      wre0       <= 1'b0;
      ad0        <= '0;
      din0       <= '0;
      ce1        <= 1'b0;
      oce1       <= 1'b0;
      wre1       <= 1'b0;
      ad1        <= '0;
      din1       <= '0;
      mem_owner  <= 1'b0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wre0       <= 1'b0;
      wre1       <= 1'b0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
      finish_q   <= fft_finish;
      case (state)
        S_LOAD: begin
          in_ready  <= 1'b1;
          ce0       <= 1'b1;
          oce0      <= 1'b1;
          ce1       <= 1'b1;
          oce1      <= 1'b1;
          mem_owner <= 1'b0;
          if (accept) begin
            if (rev[BANK]) begin
              wre1 <= 1'b1;
              ad1  <= wr_ad;
              din1 <= wr_dat;
            end else begin
              wre0 <= 1'b1;
              ad0  <= wr_ad;
              din0 <= wr_dat;
            end
            // First sample of a frame clears a stale error; an early last re-sets it below.
            if (count == '0) begin
              frame_err <= 1'b0;
            end
            if (count == LAST_IDX) begin
              state    <= S_FLUSH;
              count    <= '0;
              in_ready <= 1'b0;
              ce0      <= 1'b0;
              oce0     <= 1'b0;
              ce1      <= 1'b0;
              oce1     <= 1'b0;
            end else if (in_last) begin
              frame_err <= 1'b1;
              count     <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // The core may still hold finish high from the last frame: treat it as already seen.
          state     <= S_START;
          fft_start <= 1'b1;
          mem_owner <= 1'b1;
          finish_q  <= 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fft_finish && !finish_q) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          // Hand the banks back first; in_ready follows one cycle later.
          state     <= S_LOAD;
          mem_owner <= 1'b0;
          ce0       <= 1'b1;
          oce0      <= 1'b1;
          ce1       <= 1'b1;
          oce1      <= 1'b1;
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft1024_loader.sv
// Bench for fft1024_loader: two instances (IN_SHIFT 0 and 1) share all stimulus.
// A reference model predicts every bank write from frame position and bit reversal.
// The FFT handshake is checked against a table of per-cycle expected control outputs.
module tb_fft1024_loader;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, fft_finish;
  logic [31:0] in_data;

  logic [1:0]        in_ready_a, ce0_a, oce0_a, wre0_a, ce1_a, oce1_a, wre1_a;
  logic [1:0]        mem_owner_a, fft_start_a, frame_done_a, frame_err_a;
  logic [1:0][10:0]  ad0_a, ad1_a;
  logic [1:0][31:0]  din0_a, din1_a;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [31:0] frame_dat [1024];
  logic [31:0] mem0 [2][512];
  logic [31:0] mem1 [2][512];

  bit          exp_w [2];
  int          exp_r [2];
  logic [31:0] exp_d [2];
  bit          exp_e [2];
  int          k     [2];

  typedef struct {
    int reps;
    bit fin;
    bit vld;
    bit rdy;
    bit own;
    bit st;
    bit dn;
    bit ce;
  } row_t;
  row_t tbl [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft1024_loader #(.N(1024), .LOG2N(10), .IN_SHIFT(g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready_a[g]),
      .in_data    (in_data),
      .in_last    (in_last),
      .ce0        (ce0_a[g]),
      .oce0       (oce0_a[g]),
      .wre0       (wre0_a[g]),
      .ad0        (ad0_a[g]),
      .din0       (din0_a[g]),
      .ce1        (ce1_a[g]),
      .oce1       (oce1_a[g]),
      .wre1       (wre1_a[g]),
      .ad1        (ad1_a[g]),
      .din1       (din1_a[g]),
      .mem_owner  (mem_owner_a[g]),
      .fft_start  (fft_start_a[g]),
      .fft_finish (fft_finish),
      .frame_done (frame_done_a[g]),
      .frame_err  (frame_err_a[g])
    );
  end

  function automatic int bitrev(input int n);
    int r = 0;
    for (int i = 0; i < 10; i++) r = r * 2 + ((n >> i) & 1);
    return r;
  endfunction

  function automatic logic [31:0] scl(input logic [31:0] d, input int sh);
    logic signed [15:0] re, im;
    re = d[31:16];
    im = d[15:0];
    re = re >>> sh;
    im = im >>> sh;
    return {re, im};
  endfunction

  function automatic logic [96:0] outs(input int g);
    return {in_ready_a[g], ce0_a[g], oce0_a[g], wre0_a[g], ad0_a[g], din0_a[g],
            ce1_a[g], oce1_a[g], wre1_a[g], ad1_a[g], din1_a[g],
            mem_owner_a[g], fft_start_a[g], frame_done_a[g], frame_err_a[g]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Per-cycle write/error monitor driven by the frame-position model.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        if (exp_w[g])
          chk($sformatf("wr_g%0d_r%0d", g, exp_r[g]),
              {frame_err_a[g], wre0_a[g], wre1_a[g],
               (exp_r[g] >= 512) ? ad1_a[g] : ad0_a[g],
               (exp_r[g] >= 512) ? din1_a[g] : din0_a[g]},
              {exp_e[g], exp_r[g] < 512, exp_r[g] >= 512, 11'(exp_r[g] % 512), exp_d[g]});
        else
          chk($sformatf("idle_g%0d", g), {frame_err_a[g], wre0_a[g], wre1_a[g]}, {exp_e[g], 2'b00});
        if (wre0_a[g]) mem0[g][ad0_a[g][8:0]] = din0_a[g];
        if (wre1_a[g]) mem1[g][ad1_a[g][8:0]] = din1_a[g];
        if (rst) begin
          k[g] = 0;
          exp_e[g] = 1'b0;
          exp_w[g] = 1'b0;
        end else if (in_valid && in_ready_a[g]) begin
          exp_w[g] = 1'b1;
          exp_r[g] = bitrev(k[g]);
          exp_d[g] = scl(in_data, g);
          if (k[g] == 0) exp_e[g] = 1'b0;
          if (in_last && k[g] != 1023) exp_e[g] = 1'b1;
          k[g] = (in_last || k[g] == 1023) ? 0 : k[g] + 1;
        end else begin
          exp_w[g] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready_a[0] && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: waited %0d cycles, limit 50", w);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_frame(input int cnt, input int gap, input bit last_at_end);
    for (int n = 0; n < cnt; n++) begin
      send(frame_dat[n], last_at_end && (n == cnt - 1));
      if (n != cnt - 1) repeat (gap) step();
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        for (int g = 0; g < 2; g++)
          chk($sformatf("hs_row%0d_cyc%0d_g%0d", i, j, g),
              {in_ready_a[g], mem_owner_a[g], fft_start_a[g], frame_done_a[g],
               ce0_a[g], oce0_a[g], ce1_a[g], oce1_a[g]},
              {tbl[i].rdy, tbl[i].own, tbl[i].st, tbl[i].dn, {4{tbl[i].ce}}});
        fft_finish = tbl[i].fin;
        in_valid   = tbl[i].vld;
        in_data    = $urandom;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_image(input string nm);
    int r, nb, first;
    logic [31:0] got;
    for (int g = 0; g < 2; g++) begin
      nb = 0;
      first = -1;
      for (int n = 0; n < 1024; n++) begin
        r = bitrev(n);
        got = (r < 512) ? mem0[g][r] : mem1[g][r - 512];
        if (got !== scl(frame_dat[n], g)) begin
          nb++;
          if (first < 0) first = n;
        end
      end
      chk($sformatf("%s_image_g%0d_first_bad_sample%0d", nm, g, first), nb, 0);
    end
  endtask

  task automatic rand_frame();
    for (int n = 0; n < 1024; n++) frame_dat[n] = $urandom;
  endtask

  initial begin
    //              reps fin vld rdy own st dn ce
    tbl[0]  = '{1,  0, 1,  0, 0, 0, 0, 0};  // flush
    tbl[1]  = '{1,  0, 1,  0, 1, 1, 0, 0};  // start pulse
    tbl[2]  = '{6,  0, 1,  0, 1, 0, 0, 0};  // wait, valid ignored
    tbl[3]  = '{1,  1, 1,  0, 1, 0, 0, 0};  // wait, finish rises
    tbl[4]  = '{1,  1, 1,  0, 1, 0, 1, 0};  // done
    tbl[5]  = '{1,  0, 1,  0, 0, 0, 0, 1};  // banks handed back
    tbl[6]  = '{1,  0, 0,  1, 0, 0, 0, 1};  // ready again
    tbl[7]  = '{1,  1, 0,  0, 0, 0, 0, 0};  // flush, stale finish high
    tbl[8]  = '{1,  1, 0,  0, 1, 1, 0, 0};  // start pulse
    tbl[9]  = '{1,  1, 0,  0, 1, 0, 0, 0};  // stale level in wait
    tbl[10] = '{40, 0, 0,  0, 1, 0, 0, 0};  // finish low
    tbl[11] = '{1,  1, 0,  0, 1, 0, 0, 0};  // real rise
    tbl[12] = '{1,  1, 0,  0, 1, 0, 1, 0};  // done once
    tbl[13] = '{1,  0, 0,  0, 0, 0, 0, 1};
    tbl[14] = '{1,  0, 0,  1, 0, 0, 0, 1};
    tbl[15] = '{19, 0, 1,  0, 1, 0, 0, 0};  // wait before reset

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    fft_finish = 1'b0;
    repeat (3) step();
    for (int g = 0; g < 2; g++) chk($sformatf("reset_outs_g%0d", g), outs(g), '0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Ramp frame, sample 0 replaced by full-scale values to exercise the shift.
    for (int n = 0; n < 1024; n++) frame_dat[n] = {16'(n << 5), 16'h0000};
    frame_dat[0] = 32'h8000_7FFF;
    load_frame(1024, 0, 1'b1);
    run_rows(0, 6);
    check_image("ramp");
    chk("ramp_s1_bank1_ad0",    mem1[0][0],   32'h0020_0000);
    chk("ramp_s2_bank0_ad256",  mem0[0][256], 32'h0040_0000);
    chk("ramp_s1023_bank1_ad511", mem1[0][511], 32'h7FE0_0000);
    chk("ramp_s0_noshift",      mem0[0][0],   32'h8000_7FFF);
    chk("ramp_s0_shift1",       mem0[1][0],   32'hC000_3FFF);
    chk("ramp_s1_shift1",       mem1[1][0],   32'h0010_0000);

    // Early last on sample 99, then a full frame with finish stuck high from before.
    fft_finish = 1'b1;
    rand_frame();
    load_frame(100, 0, 1'b1);
    repeat (6) begin
      for (int g = 0; g < 2; g++)
        chk($sformatf("early_last_g%0d", g),
            {in_ready_a[g], mem_owner_a[g], fft_start_a[g], frame_err_a[g]}, 4'b1001);
      step();
    end
    rand_frame();
    send(frame_dat[0], 1'b0);
    for (int g = 0; g < 2; g++) chk($sformatf("err_clear_g%0d", g), frame_err_a[g], 1'b0);
    for (int n = 1; n < 1024; n++) send(frame_dat[n], n == 1023);
    run_rows(7, 14);
    check_image("after_err");

    // Valid one cycle in three, last flag never raised.
    rand_frame();
    load_frame(1024, 2, 1'b0);
    run_rows(0, 6);
    check_image("gapped");

    // Reset while waiting on the core, then a clean frame.
    rand_frame();
    load_frame(1024, 0, 1'b1);
    run_rows(0, 1);
    run_rows(15, 15);
    rst = 1'b1;
    step();
    for (int g = 0; g < 2; g++) chk($sformatf("wait_reset_outs_g%0d", g), outs(g), '0);
    rst = 1'b0;
    rand_frame();
    load_frame(1024, 0, 1'b1);
    run_rows(0, 6);
    check_image("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
